ripple_count_sampler: RTL and testbench

//   Synchronous capture stage downstream of the n-bit asynchronous ripple down-counter.

---
 rtl/ripple_count_sampler.sv | 104 ++++++++++
 tb/tb_ripple_count_sampler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_sampler.sv
// rtl/ripple_count_sampler.sv - synchronizes and stability-filters a ripple down-counter, counts wraps.
// Define RCS_GLITCH_CNT_EN to add the glitch_count output (values dropped before acceptance).
module ripple_count_sampler #(
  parameter int N          = 7,
  parameter int STABLE_CNT = 2,
  parameter int WRAP_W     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N-1:0]      cnt_in,
  input  logic              en,
  input  logic              wrap_clr,
  output logic [N-1:0]      cnt_out,
  output logic              cnt_valid,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count
`ifdef RCS_GLITCH_CNT_EN
  ,
  output logic [WRAP_W-1:0] glitch_count
`endif
);

  localparam logic [3:0]        R_SAT   = 4'(STABLE_CNT);
  localparam logic [3:0]        R_LAST  = 4'(STABLE_CNT - 1);
  localparam logic [WRAP_W-1:0] CNT_ONE = WRAP_W'(1);
  localparam logic [WRAP_W-1:0] CNT_MAX = '1;

  logic [N-1:0] s1;
  logic [N-1:0] s2;
  logic [N-1:0] s_prev;
  logic [3:0]   r;
  logic         match;
  logic         accept;
  logic         wrap;

  assign match  = (s2 == s_prev);
  assign accept = en && match && (r == R_LAST);
  // A down-counter only moves up at a wrap, so any accepted increase is one.
  assign wrap   = accept && cnt_valid && (s2 > cnt_out);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= '0;
      s2     <= '0;
      s_prev <= '0;
    end else begin
      s1     <= cnt_in;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  // r saturates at STABLE_CNT so a long stable run is accepted only once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r <= '0;
    end else if (!en || !match) begin
      r <= '0;
    end else if (r != R_SAT) begin
      r <= r + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
    end else if (accept) begin
      cnt_out   <= s2;
      cnt_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
    end else begin
      wrap_pulse <= wrap;
      if (wrap_clr) begin
        wrap_count <= wrap ? CNT_ONE : '0;
      end else if (wrap && (wrap_count != CNT_MAX)) begin
        wrap_count <= wrap_count + CNT_ONE;
      end
    end
  end

`ifdef RCS_GLITCH_CNT_EN
  logic drop;

  assign drop = en && !match && (r < R_SAT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_count <= '0;
    end else if (wrap_clr) begin
      glitch_count <= drop ? CNT_ONE : '0;
    end else if (drop && (glitch_count != CNT_MAX)) begin
      glitch_count <= glitch_count + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb/tb_ripple_count_sampler.sv - scoreboard bench for ripple_count_sampler against a run-length model.
module tb_ripple_count_sampler;
  localparam int N    = 7;
  localparam int SC   = 2;
  localparam int WW   = 2;
  localparam int WMAX = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  cnt_in;
  logic          en;
  logic          wrap_clr;
  logic [N-1:0]  cnt_out;
  logic          cnt_valid;
  logic          wrap_pulse;
  logic [WW-1:0] wrap_count;
`ifdef RCS_GLITCH_CNT_EN
  logic [WW-1:0] glitch_count;
`endif

  always #5 clk = ~clk;

  ripple_count_sampler #(.N(N), .STABLE_CNT(SC), .WRAP_W(WW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cnt_in     (cnt_in),
    .en         (en),
    .wrap_clr   (wrap_clr),
    .cnt_out    (cnt_out),
    .cnt_valid  (cnt_valid),
    .wrap_pulse (wrap_pulse),
`ifdef RCS_GLITCH_CNT_EN
    .glitch_count (glitch_count),
`endif
    .wrap_count (wrap_count)
  );

  typedef struct {
    logic [N-1:0] out;
    logic         valid;
    logic         pulse;
    int           wc;
    int           gc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: sample history plus an unbounded run length of matching enabled edges.
  logic [N-1:0] hist [3];
  int           run;
  logic [N-1:0] m_out;
  logic         m_valid;
  logic         m_pulse;
  int           m_wc;
  int           m_gc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    run = 0; m_out = '0; m_valid = 1'b0; m_pulse = 1'b0; m_wc = 0; m_gc = 0;
  endtask

  task automatic model_edge();
    exp_t e;
    bit   match, accept, drop, wrap;
    int   run_old;
    if (!reset_n) begin
      model_reset();
    end else begin
      match   = (hist[1] == hist[2]);
      run_old = run;
      run     = (en && match) ? run + 1 : 0;
      accept  = en && match && (run == SC);
      drop    = en && !match && (run_old < SC);
      wrap    = accept && m_valid && (hist[1] > m_out);
      if (accept) begin
        m_out   = hist[1];
        m_valid = 1'b1;
      end
      m_pulse = wrap;
      if (wrap_clr) m_wc = wrap ? 1 : 0;
      else if (wrap && m_wc < WMAX) m_wc++;
      if (wrap_clr) m_gc = drop ? 1 : 0;
      else if (drop && m_gc < WMAX) m_gc++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = cnt_in;
    end
    e.out = m_out; e.valid = m_valid; e.pulse = m_pulse; e.wc = m_wc; e.gc = m_gc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic hold(input logic [N-1:0] v, input int n);
    cnt_in = v;
    repeat (n) tick();
  endtask

  task automatic chk_zero_outputs();
    chk("rst_cnt_out", cnt_out, 0);
    chk("rst_cnt_valid", cnt_valid, 0);
    chk("rst_wrap_pulse", wrap_pulse, 0);
    chk("rst_wrap_count", wrap_count, 0);
`ifdef RCS_GLITCH_CNT_EN
    chk("rst_glitch_count", glitch_count, 0);
`endif
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("sb_cnt_out", cnt_out, mon_e.out);
      chk("sb_cnt_valid", cnt_valid, mon_e.valid);
      chk("sb_wrap_pulse", wrap_pulse, mon_e.pulse);
      chk("sb_wrap_count", wrap_count, mon_e.wc);
`ifdef RCS_GLITCH_CNT_EN
      chk("sb_glitch_count", glitch_count, mon_e.gc);
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] v;
    int           n;
    reset_n = 1'b0; en = 1'b0; wrap_clr = 1'b0; cnt_in = 7'h05;
    model_reset();
    #1;
    chk_zero_outputs();
    tick(); tick();
    reset_n = 1'b1;

    // First value after reset: 4 edges from first sample to cnt_out.
    tick(); tick();
    en = 1'b1;
    tick(); tick();
    chk("t1_valid_early", cnt_valid, 0);
    tick();
    chk("t1_valid", cnt_valid, 1);
    chk("t1_cnt_out", cnt_out, 7'h05);
    chk("t1_no_pulse", wrap_pulse, 0);
    tick();

    // 01 -> 00 -> 7F: single wrap on the 7F accept.
    hold(7'h01, 6);
    hold(7'h00, 6);
    cnt_in = 7'h7F;
    repeat (5) tick();
    chk("t2_pulse", wrap_pulse, 1);
    tick();
    chk("t2_pulse_end", wrap_pulse, 0);
    chk("t2_wrap_count", wrap_count, 1);
    wrap_clr = 1'b1;
    tick();
    wrap_clr = 1'b0;

    // One-cycle transient between two stable codes.
    hold(7'h41, 6);
    hold(7'h40, 1);
    hold(7'h3F, 6);
    chk("t3_cnt_out", cnt_out, 7'h3F);
    chk("t3_wrap_count", wrap_count, 0);
`ifdef RCS_GLITCH_CNT_EN
    chk("t3_glitch_count", glitch_count, 1);
`endif

    // Saturation of the narrow wrap counter, then clear coinciding with a wrap.
    for (int i = 0; i < 4; i++) begin
      hold(7'h00, 6);
      hold(7'h7F, 6);
    end
    chk("t4_saturated", wrap_count, 3);
    hold(7'h00, 6);
    cnt_in = 7'h7F;
    repeat (4) tick();
    wrap_clr = 1'b1;
    tick();
    wrap_clr = 1'b0;
    chk("t4_clr_and_wrap", wrap_count, 1);
    chk("t4_pulse", wrap_pulse, 1);
    tick();

    // Freeze while disabled, catch up once re-enabled.
    hold(7'h10, 6);
    chk("t5_cnt_out", cnt_out, 7'h10);
    en = 1'b0;
    hold(7'h0F, 6);
    chk("t5_frozen", cnt_out, 7'h10);
    en = 1'b1;
    repeat (SC + 1) tick();
    chk("t5_resumed", cnt_out, 7'h0F);

    // Asynchronous reset mid-run; next value is a first accept.
    hold(7'h22, 6);
    chk("t6_cnt_out", cnt_out, 7'h22);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs();
    model_reset();
    cnt_in = 7'h7F; en = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    en = 1'b1;
    tick(); tick(); tick();
    chk("t6_valid", cnt_valid, 1);
    chk("t6_cnt_out", cnt_out, 7'h7F);
    chk("t6_no_pulse", wrap_pulse, 0);
    chk("t6_wrap_count", wrap_count, 0);

    // Randomized down-counting with transients, enable drops and clears.
    v = cnt_in;
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 19) != 0);
      wrap_clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) begin
        cnt_in = 7'($urandom);
        tick();
      end
      v      = v - 7'($urandom_range(1, 2));
      cnt_in = v;
      n      = $urandom_range(1, 6);
      tick();
      wrap_clr = 1'b0;
      repeat (n - 1) tick();
    end

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
